// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the CPU run controller: FSM states, run modes, stop causes
// and default parameter values.
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } run_state_t;

  localparam logic [1:0] MODE_RUN_N     = 2'd0;
  localparam logic [1:0] MODE_RUN_UNTIL = 2'd1;
  localparam logic [1:0] MODE_STEP      = 2'd2;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_LIMIT = 3'd1;
  localparam logic [2:0] CAUSE_HALT  = 3'd2;
  localparam logic [2:0] CAUSE_BP    = 3'd3;
  localparam logic [2:0] CAUSE_STALL = 3'd4;
  localparam logic [2:0] CAUSE_SAT   = 3'd5;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_NUM_BP      = 4;
  localparam int DEF_RST_CYCLES  = 2;
  localparam int DEF_STALL_LIMIT = 8;

endpackage

// File: rtl/cpu_run_ctrl_bp_match.sv
// PC breakpoint matcher: parallel equality compares, OR-reduced hit and the
// lowest matching slot index.
module run_bp_match #(
  parameter int ADDR_W = 32,
  parameter int NUM_BP = 4
) (
  input  logic [ADDR_W-1:0]        pc,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  output logic                     hit,
  output logic [3:0]               idx
);

  // Scan high to low so the last assignment wins with the lowest index.
  always_comb begin
    hit = 1'b0;
    idx = 4'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (bp_addr[i*ADDR_W +: ADDR_W] == pc)) begin
        hit = 1'b1;
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for a MIPS core: reset pulse, per-cycle clock enable, cycle
// counting and stopping on limit, halt, breakpoint, PC stall or count saturation.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int NUM_BP      = DEF_NUM_BP,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [CNT_W-1:0]         cycle_limit,
  input  logic                     step,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [ADDR_W-1:0]        pc,
  input  logic                     cpu_halt,
  output logic                     cpu_rst,
  output logic                     cpu_en,
  output logic [CNT_W-1:0]         cycle_count,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               cause,
  output run_state_t               state_dbg,
  output logic [3:0]               bp_idx_dbg
);

  localparam int SW   = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam int RC_W = $clog2(RST_CYCLES + 1);

  run_state_t        state, state_n;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  limit_q, cnt_q;
  logic [2:0]        cause_q, stop_cause;
  logic [SW-1:0]     stall_q;
  logic [ADDR_W-1:0] prev_pc;
  logic              first_q;
  logic [RC_W-1:0]   rst_cnt;
  logic              bp_hit, stall_hit, limit_hit, sat_hit, stop, launch;

  run_bp_match #(.ADDR_W(ADDR_W), .NUM_BP(NUM_BP)) u_bp (
    .pc      (pc),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .hit     (bp_hit),
    .idx     (bp_idx_dbg)
  );

  assign stall_hit = (STALL_LIMIT > 0) && (stall_q == SW'(STALL_LIMIT));
  // RUN_UNTIL treats a zero limit as unbounded; every other mode stops at it.
  assign limit_hit = (mode_q == MODE_RUN_UNTIL) ? ((limit_q != '0) && (cnt_q == limit_q))
                                                : (cnt_q == limit_q);
  assign sat_hit   = &cnt_q;
  assign launch    = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_comb begin
    stop_cause = CAUSE_NONE;
    if (cpu_halt)       stop_cause = CAUSE_HALT;
    else if (bp_hit)    stop_cause = CAUSE_BP;
    else if (stall_hit) stop_cause = CAUSE_STALL;
    else if (limit_hit) stop_cause = CAUSE_LIMIT;
    else if (sat_hit)   stop_cause = CAUSE_SAT;
  end

  assign stop = ((state == ST_RUN) || (state == ST_STEP)) && (stop_cause != CAUSE_NONE);

  always_comb begin
    state_n = state;
    cpu_en  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_n = ST_RESET;
      ST_RESET: if (rst_cnt == RC_W'(RST_CYCLES - 1))
                  state_n = (mode_q == MODE_STEP) ? ST_STEP : ST_RUN;
      ST_RUN:   if (stop) state_n = ST_DONE; else cpu_en = 1'b1;
      ST_STEP:  if (stop) state_n = ST_DONE; else cpu_en = step;
      ST_DONE:  if (start) state_n = ST_RESET;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_RUN_N;
      limit_q <= '0;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
      stall_q <= '0;
      prev_pc <= '0;
      first_q <= 1'b0;
      rst_cnt <= '0;
    end else begin
      state <= state_n;
      if (launch) begin
        mode_q  <= mode;
        limit_q <= cycle_limit;
        cnt_q   <= '0;
        cause_q <= CAUSE_NONE;
        stall_q <= '0;
        first_q <= 1'b1;
        rst_cnt <= '0;
      end
      if (state == ST_RESET) rst_cnt <= rst_cnt + RC_W'(1);
      if (cpu_en) begin
        cnt_q   <= cnt_q + CNT_W'(1);
        prev_pc <= pc;
        first_q <= 1'b0;
        // The stall count compares against the PC of the previous enabled cycle only.
        if (first_q || (pc != prev_pc)) stall_q <= '0;
        else if (stall_q != SW'(STALL_LIMIT)) stall_q <= stall_q + SW'(1);
      end
      if (stop) cause_q <= stop_cause;
    end
  end

  assign cpu_rst     = (state == ST_IDLE) || (state == ST_RESET);
  assign busy        = (state == ST_RESET) || (state == ST_RUN) || (state == ST_STEP);
  assign done        = (state == ST_DONE);
  assign cause       = cause_q;
  assign cycle_count = cnt_q;
  assign state_dbg   = state;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Synthesizable run controller that sequences a MIPS CPU core for simulation and board-level bring-up.
- Generates the core's reset pulse and a per-cycle clock enable.
- Counts executed cycles and stops the core on a cycle limit, a halt signal, a PC breakpoint or a PC stall.
- Sits between the top-level test harness and the CPU; replaces fixed-count free-running with configurable run modes.

Parameters:
ADDR_W, 32, width of PC and breakpoint addresses
CNT_W, 32, width of cycle counter and limit
NUM_BP, 4, number of PC breakpoint comparators (1..16)
RST_CYCLES, 2, cycles cpu_rst held after start (>=1)
STALL_LIMIT, 8, consecutive enabled cycles with unchanged PC that flag a stall; 0 disables

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, begins a run; ignored while busy
mode  in  2  0=RUN_N, 1=RUN_UNTIL, 2=STEP, 3=reserved (treated as RUN_N)
cycle_limit  in  CNT_W  enabled-cycle budget; latched on start
step  in  1  in STEP mode, each high cycle enables one CPU cycle
bp_addr  in  NUM_BP*ADDR_W  packed breakpoint addresses, slot i at [i*ADDR_W +: ADDR_W]
bp_en  in  NUM_BP  per-slot breakpoint enable
pc  in  ADDR_W  current CPU PC (registered in the core)
cpu_halt  in  1  core reports halt (break/syscall)
cpu_rst  out  1  reset to CPU core
cpu_en  out  1  CPU clock enable
cycle_count  out  CNT_W  enabled cycles since last start
busy  out  1  run in progress (RESET/RUN/STEP)
done  out  1  level, run finished; cleared by next start
cause  out  3  0=none, 1=limit, 2=halt, 3=breakpoint, 4=stall, 5=count saturated

Behaviour:
- States: IDLE, RESET, RUN, STEP, DONE.
- On rst (any state, mid-run included): state=IDLE, cpu_rst=1, cpu_en=0, cycle_count=0, busy=0, done=0, cause=0; all latched mode/limit and stall counters cleared.
- IDLE: cpu_rst=1, cpu_en=0. A start pulse:
  - latches mode and cycle_limit;
  - clears cycle_count, done, cause and the stall counter;
  - moves to RESET.
- RESET: cpu_rst=1 for exactly RST_CYCLES cycles; then RUN (mode 0/1/3) or STEP (mode 2). cpu_rst=0 in RUN/STEP/DONE.
- cpu_en is combinational:
  - RUN: cpu_en=1 unless a stop condition holds this cycle.
  - STEP: cpu_en=step unless a stop condition holds this cycle.
  - All other states: cpu_en=0.
  - A cycle that stops therefore does not execute; e.g. the instruction at a breakpoint PC is not executed.
- cycle_count increments by 1 on each cpu_en=1 cycle.
- Stop conditions, evaluated every RUN/STEP cycle; highest priority wins:
  1. cpu_halt=1 -> cause 2.
  2. Any i with bp_en[i] && pc==bp_addr[i] -> cause 3.
  3. Stall counter==STALL_LIMIT (STALL_LIMIT>0) -> cause 4.
  4. Limit reached, cause 1:
     - RUN_N/STEP: cycle_count==latched limit.
     - RUN_UNTIL: latched limit !=0 && cycle_count==limit; limit 0 = unbounded.
  5. cycle_count all-ones -> cause 5.
- On a stop: next state DONE, cause registered, done=1, busy=0 from the next cycle.
- Limit 0 in RUN_N: stops on the first RUN cycle with cycle_count=0.
- Stall counter:
  - On an enabled cycle, if pc equals the PC of the previous enabled cycle, increment (saturating at STALL_LIMIT); otherwise clear.
  - The first enabled cycle after RESET clears it.
- DONE:
  - cpu_en=0 and cpu_rst=0, so CPU state is held for inspection.
  - cycle_count and cause are held.
  - start re-enters RESET as from IDLE.
- busy = state in {RESET, RUN, STEP}. start while busy has no effect.
- Widths: comparisons are unsigned, full width. No wrap: count saturation stops the run.

Decomposition:
- Shared package/header: state encoding, mode codes, cause codes (localparam/define), default parameter values.
- Sub-module: run_bp_match:
  - NUM_BP parallel equality comparators plus OR-reduction, combinational.
  - Outputs hit and lowest matching index (index exposed for debug only).

Test Plan:
- RUN_N, cycle_limit=10, no bp, pc incrementing by 4 -> cpu_rst high 2 cycles after start; cpu_en high exactly 10 cycles; done=1, cause=1, cycle_count=10.
- RUN_UNTIL, limit=0, bp_en=4'b0010, bp_addr slot1=0x00000020, pc from 0 step 4 -> cpu_en low in the cycle pc=0x20; cause=3, cycle_count=8.
- RUN_UNTIL, cpu_halt asserted in the same cycle pc hits a breakpoint -> cause=2 (halt wins); cpu_en=0 that cycle.
- RUN_UNTIL, STALL_LIMIT=8, pc held at 0x40 from cycle 5 -> stop once the stall counter reaches 8; cause=4; count matches a hand-computed value.
- STEP, limit=3, step pulsed 5 times with gaps -> cpu_en mirrors only the first 3 pulses; cause=1, cycle_count=3; the 4th pulse is not enabled.
- rst asserted mid-RUN at count 5, then start with RUN_N limit=2 -> outputs reset next cycle; second run completes with cycle_count=2; start pulses during busy are ignored.
